// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID checker and the system-ID slave generation.
package sysid_pkg;

  typedef enum logic [2:0] {
    RD_ID,
    LAT_ID,
    RD_TS,
    LAT_TS,
    DONE
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  // Build timestamp also baked into the generated system-ID slave.
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1383139318;

endpackage

// File: rtl/sysid_rd_timer.sv
// Down-counter shared by the read-latency wait and the waitrequest timeout.
// expire fires on the tick that brings the count to its terminal value.
module sysid_rd_timer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        tick,
  output logic        expire
);

  logic [15:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && count != 16'd0) begin
      count <= count - 16'd1;
    end
  end

  assign expire = tick && (count == 16'd1);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM master that reads system ID and build timestamp after reset or on
// request, and reports whether both match the values built into the hardware.
//
// state  | meaning
// RD_ID  | read word 0 (avm_read=0 here only on the first clock after reset)
// LAT_ID | waiting READ_LATENCY cycles for ID data
// RD_TS  | read word 1
// LAT_TS | waiting READ_LATENCY cycles for timestamp data
// DONE   | results valid, waiting for start
module sysid_checker import sysid_pkg::*; #(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int          READ_LATENCY   = 0,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout
);

  localparam logic [15:0] LAT_LOAD = 16'(READ_LATENCY);
  localparam logic [15:0] TO_LOAD  = 16'(TIMEOUT_CYCLES);
  localparam bit          HAS_LAT  = (READ_LATENCY != 0);

  sysid_state_t state;

  logic        in_rd, in_lat, accept, stall, cap_now, cap_ts;
  logic        tmr_load, tmr_tick, tmr_expire;
  logic [15:0] tmr_value;

  assign in_rd  = (state == RD_ID) || (state == RD_TS);
  assign in_lat = (state == LAT_ID) || (state == LAT_TS);
  assign accept = in_rd && avm_read && !avm_waitrequest;
  assign stall  = in_rd && avm_read && avm_waitrequest;
  assign cap_ts = (state == RD_TS) || (state == LAT_TS);

  // With zero latency the data is taken in the accept cycle itself.
  assign cap_now = (accept && !HAS_LAT) || (in_lat && tmr_expire);

  // Timer reloads for the timeout whenever a read is launched, and for the
  // latency wait when a read is accepted on a slave with fixed latency.
  assign tmr_load  = (in_rd && (!avm_read || accept)) || (in_lat && tmr_expire) ||
                     ((state == DONE) && start);
  assign tmr_value = (accept && HAS_LAT) ? LAT_LOAD : TO_LOAD;
  assign tmr_tick  = stall || in_lat;

  sysid_rd_timer u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tick       (tmr_tick),
    .expire     (tmr_expire)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RD_ID;
      avm_address <= SYSID_ADDR_ID;
      avm_read    <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
    end else if (cap_now) begin
      if (!cap_ts) begin
        id_value    <= avm_readdata;
        avm_address <= SYSID_ADDR_TS;
        avm_read    <= 1'b1;
        state       <= RD_TS;
      end else begin
        ts_value <= avm_readdata;
        avm_read <= 1'b0;
        done     <= 1'b1;
        id_ok    <= (id_value == EXPECTED_ID);
        ts_ok    <= (avm_readdata == EXPECTED_TS);
        state    <= DONE;
      end
    end else begin
      case (state)
        RD_ID, RD_TS: begin
          if (!avm_read) begin
            avm_read <= 1'b1;
          end else if (accept) begin
            avm_read <= 1'b0;
            state    <= (state == RD_ID) ? LAT_ID : LAT_TS;
          end else if (tmr_expire) begin
            avm_read <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          if (start) begin
            avm_address <= SYSID_ADDR_ID;
            avm_read    <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            state       <= RD_ID;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Runs two checkers (latency 0 and 2) against a behavioural Avalon slave and
// predicts completion cycle and results from the read/stall/timeout rules.
module tb_sysid_checker;

  localparam int          TO     = 8;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1383139318;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address [2];
  logic        avm_read    [2];
  logic [31:0] slv_rd      [2];
  logic        slv_wr      [2];
  logic [31:0] id_value    [2];
  logic [31:0] ts_value    [2];
  logic        done        [2];
  logic        id_ok       [2];
  logic        ts_ok       [2];
  logic        timeout     [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sysid_checker #(.READ_LATENCY(0), .TIMEOUT_CYCLES(TO)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address[0]), .avm_read(avm_read[0]),
    .avm_readdata(slv_rd[0]), .avm_waitrequest(slv_wr[0]),
    .id_value(id_value[0]), .ts_value(ts_value[0]), .done(done[0]),
    .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout(timeout[0])
  );

  sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(TO)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address[1]), .avm_read(avm_read[1]),
    .avm_readdata(slv_rd[1]), .avm_waitrequest(slv_wr[1]),
    .id_value(id_value[1]), .ts_value(ts_value[1]), .done(done[1]),
    .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout(timeout[1])
  );

  function automatic int lat(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Slave plan for the current trial: stalls per word and the word contents.
  int          plan_sid, plan_sts;
  logic [31:0] words [2];
  int          trial_id = 0;

  int   seen [2] = '{-1, -1};
  int   stall_left [2][2];
  int   pend [2];
  logic pend_addr [2];
  logic prev_stalled [2];
  logic prev_addr [2];
  logic vld;

  // Slave decides waitrequest and readdata on the falling edge for the next rising edge.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (seen[i] != trial_id) begin
        seen[i]          = trial_id;
        stall_left[i][0] = plan_sid;
        stall_left[i][1] = plan_sts;
        pend[i]          = 0;
        prev_stalled[i]  = 1'b0;
      end
      if (!reset_n) begin
        slv_wr[i]       = 1'b0;
        slv_rd[i]       = $urandom;
        pend[i]         = 0;
        prev_stalled[i] = 1'b0;
      end else begin
        if (prev_stalled[i] && !done[i])
          chk($sformatf("hold%0d", i), {avm_read[i], avm_address[i]}, {1'b1, prev_addr[i]});
        vld = 1'b0;
        if (pend[i] > 0) begin
          pend[i]--;
          if (pend[i] == 0) begin
            slv_rd[i] = words[pend_addr[i]];
            vld = 1'b1;
          end
        end
        if (avm_read[i] && stall_left[i][avm_address[i]] > 0) begin
          slv_wr[i] = 1'b1;
          stall_left[i][avm_address[i]]--;
        end else begin
          slv_wr[i] = 1'b0;
        end
        prev_stalled[i] = avm_read[i] && slv_wr[i];
        prev_addr[i]    = avm_address[i];
        if (avm_read[i] && !slv_wr[i]) begin
          if (lat(i) == 0) begin
            slv_rd[i] = words[avm_address[i]];
            vld = 1'b1;
          end else begin
            pend[i]      = lat(i);
            pend_addr[i] = avm_address[i];
          end
        end
        if (!vld) slv_rd[i] = $urandom;
      end
    end
  end

  logic [31:0] prev_id [2];
  logic [31:0] prev_ts [2];

  task automatic run_check(input bit via_reset, input int sid, input int sts,
                           input logic [31:0] w0, input logic [31:0] w1, input bit extra_start);
    int dc [2];
    int edge_e, c;
    bit to_e;
    logic [31:0] id_e, ts_e;
    plan_sid = sid;
    plan_sts = sts;
    words[0] = w0;
    words[1] = w1;
    trial_id++;
    if (via_reset) begin
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rst_ctl%0d", i),
            {avm_read[i], avm_address[i], done[i], id_ok[i], ts_ok[i], timeout[i]}, 0);
        chk($sformatf("rst_val%0d", i), {id_value[i], ts_value[i]}, 0);
        prev_id[i] = '0;
        prev_ts[i] = '0;
      end
      @(posedge clock);
      #1 reset_n = 1'b1;
    end else begin
      start = 1'b1;
    end
    dc[0] = 0;
    dc[1] = 0;
    for (int k = 1; k <= 60 && (dc[0] == 0 || dc[1] == 0); k++) begin
      @(posedge clock);
      #1;
      if (k == 1) start = 1'b0;
      if (k == 2 && extra_start) start = 1'b1;
      if (k == 3) start = 1'b0;
      for (int i = 0; i < 2; i++)
        if (done[i] && dc[i] == 0) dc[i] = k;
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      to_e = 1'b0;
      id_e = prev_id[i];
      ts_e = prev_ts[i];
      if (sid >= TO) begin
        edge_e = 1 + TO;
        to_e   = 1'b1;
      end else begin
        id_e = w0;
        c    = 2 + sid + lat(i);
        if (sts >= TO) begin
          edge_e = c + TO;
          to_e   = 1'b1;
        end else begin
          ts_e   = w1;
          edge_e = c + 1 + sts + lat(i);
        end
      end
      chk($sformatf("done_cycle%0d", i), dc[i], edge_e);
      chk($sformatf("values%0d", i), {id_value[i], ts_value[i]}, {id_e, ts_e});
      chk($sformatf("flags%0d", i), {id_ok[i], ts_ok[i], timeout[i]},
          {!to_e && (id_e == EXP_ID), !to_e && (ts_e == EXP_TS), to_e});
      prev_id[i] = id_e;
      prev_ts[i] = ts_e;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w0, w1;
    int sid, sts;
    reset_n  = 1'b0;
    start    = 1'b0;
    plan_sid = 0;
    plan_sts = 0;
    words[0] = EXP_ID;
    words[1] = EXP_TS;
    repeat (2) @(posedge clock);
    #1;

    run_check(1'b1, 0, 0, EXP_ID, EXP_TS, 1'b0);
    run_check(1'b0, 0, 0, EXP_ID, EXP_TS + 32'd1, 1'b0);
    run_check(1'b0, 5, 0, EXP_ID, EXP_TS, 1'b1);
    run_check(1'b1, 1000, 0, EXP_ID, EXP_TS, 1'b0);
    run_check(1'b0, 0, 3, 32'h1234_5678, EXP_TS, 1'b0);

    // Reset while the timestamp read is outstanding on both checkers.
    plan_sid = 0;
    plan_sts = 6;
    trial_id++;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    for (int i = 0; i < 2; i++)
      chk($sformatf("busy%0d", i), {avm_read[i], avm_address[i]}, 2'b11);
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("rst_drop%0d", i), avm_read[i], 1'b0);
    run_check(1'b1, 0, 0, EXP_ID, EXP_TS, 1'b0);
    run_check(1'b0, 0, 0, EXP_ID, EXP_TS, 1'b0);

    for (int t = 0; t < 40; t++) begin
      sid = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(10, 0);
      sts = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(10, 0);
      w0  = ($urandom_range(9, 0) < 7) ? EXP_ID : 32'($urandom);
      w1  = ($urandom_range(9, 0) < 7) ? EXP_TS : 32'($urandom);
      run_check($urandom_range(4, 0) == 0, sid, sts, w0, w1, 1'($urandom_range(1, 0)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
